// File: rtl/pgr_uart_pkg.sv
// ----------------------------------------------------------------------------
// pgr_uart_pkg
// Shared types and constants for the UART receive engine: FSM state encoding,
// oversampling positions, word-length codes, parity-type codes and a helper
// that turns the 2-bit word-length code into a data-bit count.
// ----------------------------------------------------------------------------
package pgr_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } rx_state_t;

    // Oversampling: ticks per bit and the three tick positions that are voted
    localparam int unsigned OVERSAMPLE_DEFAULT = 6;
    localparam int unsigned SAMPLE_LO          = 2;
    localparam int unsigned SAMPLE_MID         = 3;
    localparam int unsigned SAMPLE_HI          = 4;

    // Word-length codes (data bits = 5 + code)
    localparam logic [1:0] WL_5BIT = 2'd0;
    localparam logic [1:0] WL_6BIT = 2'd1;
    localparam logic [1:0] WL_7BIT = 2'd2;
    localparam logic [1:0] WL_8BIT = 2'd3;

    // Parity type codes
    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    function automatic logic [3:0] data_bits(input logic [1:0] word_len);
        return 4'd5 + {2'b00, word_len};
    endfunction

endpackage

// File: rtl/pgr_uart_rx_sync_filter.sv
// ----------------------------------------------------------------------------
// pgr_uart_rx_sync_filter
// Front end of the UART receiver: brings the asynchronous rxd line into the
// clk domain, detects a high-to-low transition between successive oversample
// ticks and forms a 3-sample majority vote of the line within each bit.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   i_clk_en     in   oversample tick
//   i_rxd        in   raw serial input (asynchronous, idle high)
//   i_tick_cnt   in   position of the current tick within the bit
//   o_rxd_sync   out  synchronized rxd
//   o_fall_edge  out  on a tick: line is 0 now and was 1 on the previous tick
//   o_bit_val    out  majority of the samples at SAMPLE_LO, SAMPLE_MID and the
//                     current line value; meaningful on the SAMPLE_HI tick
// ----------------------------------------------------------------------------
module pgr_uart_rx_sync_filter
    import pgr_uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clk_en,
    input  logic             i_rxd,
    input  logic [CNT_W-1:0] i_tick_cnt,
    output logic             o_rxd_sync,
    output logic             o_fall_edge,
    output logic             o_bit_val
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev_tick;
    logic                   r_samp_lo;
    logic                   r_samp_mid;
    logic                   w_rxd_sync;

    // Synchronizer resets to the idle level so reset release never looks
    // like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rxd};
        end
    end

    assign w_rxd_sync = r_sync[SYNC_STAGES-1];

    // The previous-tick value is tracked on every tick, including inside a
    // frame, so a line stuck low after a break cannot retrigger a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_tick <= 1'b1;
            r_samp_lo   <= 1'b1;
            r_samp_mid  <= 1'b1;
        end else if (i_clk_en) begin
            r_prev_tick <= w_rxd_sync;
            if (i_tick_cnt == CNT_W'(SAMPLE_LO)) begin
                r_samp_lo <= w_rxd_sync;
            end
            if (i_tick_cnt == CNT_W'(SAMPLE_MID)) begin
                r_samp_mid <= w_rxd_sync;
            end
        end
    end

    assign o_rxd_sync  = w_rxd_sync;
    assign o_fall_edge = i_clk_en & r_prev_tick & ~w_rxd_sync;

    // Third vote input is the live sample taken on the SAMPLE_HI tick itself
    assign o_bit_val   = (r_samp_lo & r_samp_mid) |
                         (r_samp_lo & w_rxd_sync) |
                         (r_samp_mid & w_rxd_sync);

endmodule

// File: rtl/pgr_uart_rx_32bit.sv
// ----------------------------------------------------------------------------
// pgr_uart_rx_32bit
// UART receive engine. Oversamples rxd with the clk_en tick, deframes
// start / 5-8 data bits / optional parity / 1-2 stop bits in LSB-first or
// MSB-first order, and writes each word right-justified into the RX FIFO
// together with one-clk error pulses.
//
// Ports:
//   clk                 in   system clock
//   rst_n               in   asynchronous active-low reset
//   i_clk_en            in   oversample tick (OVERSAMPLE x baud), one clk wide
//   i_rxd               in   serial input, asynchronous, idle high
//   i_uart_word_len     in   data bits = 5 + value
//   i_uart_parity_en    in   1 = parity bit present
//   i_uart_parity_type  in   0 = even, 1 = odd
//   i_uart_stop_len     in   0 = 1 stop bit, 1 = 2 stop bits
//   i_uart_mode         in   0 = LSB first, 1 = MSB first
//   i_rx_fifo_full      in   RX FIFO cannot accept a write
//   o_rx_fifo_wr_data   out  received word, right-justified, unused MSBs 0
//   o_rx_fifo_wr_en     out  one-clk write strobe
//   o_rx_parity_err     out  one-clk pulse with frame completion
//   o_rx_frame_err      out  one-clk pulse, a stop bit was sampled low
//   o_rx_overrun_err    out  one-clk pulse, word dropped because FIFO full
//   o_rx_busy           out  high from start detection until back in IDLE
// ----------------------------------------------------------------------------
module pgr_uart_rx_32bit
    import pgr_uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clk_en,
    input  logic       i_rxd,
    input  logic [1:0] i_uart_word_len,
    input  logic       i_uart_parity_en,
    input  logic       i_uart_parity_type,
    input  logic       i_uart_stop_len,
    input  logic       i_uart_mode,
    input  logic       i_rx_fifo_full,
    output logic [7:0] o_rx_fifo_wr_data,
    output logic       o_rx_fifo_wr_en,
    output logic       o_rx_parity_err,
    output logic       o_rx_frame_err,
    output logic       o_rx_overrun_err,
    output logic       o_rx_busy
);

    localparam int unsigned      CNT_W    = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(SAMPLE_HI);

    rx_state_t        r_state;
    rx_state_t        w_next_state;
    logic [CNT_W-1:0] r_tick;
    logic [7:0]       r_word;
    logic [3:0]       r_bit_cnt;
    logic             r_par_acc;
    logic             r_perr;
    logic             r_ferr;

    // Frame configuration, frozen at start detection
    logic [1:0]       r_word_len;
    logic             r_parity_en;
    logic             r_parity_type;
    logic             r_stop_len;
    logic             r_mode;

    logic             w_rxd_sync;
    logic             w_fall_edge;
    logic             w_bit_val;
    logic             w_vote_tick;
    logic             w_bound_tick;
    logic             w_start;
    logic             w_cap_data;
    logic             w_cap_parity;
    logic             w_cap_stop;
    logic             w_done;
    logic [3:0]       w_nbits;
    logic [2:0]       w_bit_idx;

    pgr_uart_rx_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) u_sync_filter (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clk_en    (i_clk_en),
        .i_rxd       (i_rxd),
        .i_tick_cnt  (r_tick),
        .o_rxd_sync  (w_rxd_sync),
        .o_fall_edge (w_fall_edge),
        .o_bit_val   (w_bit_val)
    );

    assign w_vote_tick  = i_clk_en && (r_tick == CNT_VOTE);
    assign w_bound_tick = i_clk_en && (r_tick == CNT_LAST);
    assign w_nbits      = data_bits(r_word_len);

    // MSB-first frames fill the word from the top of the configured width
    // down, so the result is still right-justified.
    assign w_bit_idx    = r_mode ? 3'(w_nbits - 4'd1 - r_bit_cnt) : r_bit_cnt[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Bits are judged on the vote tick and states advance on the bit
    // boundary; the last stop bit completes the frame at its vote tick so the
    // FSM is back in IDLE before the next start edge can arrive.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_cap_data   = 1'b0;
        w_cap_parity = 1'b0;
        w_cap_stop   = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_fall_edge && !w_rxd_sync) begin
                    w_start      = 1'b1;
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                if (w_vote_tick && w_bit_val) begin
                    w_next_state = ST_IDLE;
                end else if (w_bound_tick) begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_vote_tick) begin
                    w_cap_data = 1'b1;
                end
                if (w_bound_tick && (r_bit_cnt == w_nbits)) begin
                    w_next_state = r_parity_en ? ST_PARITY : ST_STOP1;
                end
            end
            ST_PARITY: begin
                if (w_vote_tick) begin
                    w_cap_parity = 1'b1;
                end
                if (w_bound_tick) begin
                    w_next_state = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (w_vote_tick) begin
                    w_cap_stop = 1'b1;
                    if (!r_stop_len) begin
                        w_done       = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end else if (w_bound_tick) begin
                    w_next_state = ST_STOP2;
                end
            end
            ST_STOP2: begin
                if (w_vote_tick) begin
                    w_cap_stop   = 1'b1;
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Frame datapath: the start-detect tick counts as tick 0 of the start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick        <= '0;
            r_word        <= '0;
            r_bit_cnt     <= '0;
            r_par_acc     <= 1'b0;
            r_perr        <= 1'b0;
            r_ferr        <= 1'b0;
            r_word_len    <= '0;
            r_parity_en   <= 1'b0;
            r_parity_type <= 1'b0;
            r_stop_len    <= 1'b0;
            r_mode        <= 1'b0;
        end else begin
            if (w_start) begin
                r_tick        <= '0;
                r_word        <= '0;
                r_bit_cnt     <= '0;
                r_par_acc     <= 1'b0;
                r_perr        <= 1'b0;
                r_ferr        <= 1'b0;
                r_word_len    <= i_uart_word_len;
                r_parity_en   <= i_uart_parity_en;
                r_parity_type <= i_uart_parity_type;
                r_stop_len    <= i_uart_stop_len;
                r_mode        <= i_uart_mode;
            end else if (i_clk_en && (r_state != ST_IDLE)) begin
                r_tick <= (r_tick == CNT_LAST) ? '0 : r_tick + 1'b1;
            end

            if (w_cap_data) begin
                r_word[w_bit_idx] <= w_bit_val;
                r_bit_cnt         <= r_bit_cnt + 4'd1;
                r_par_acc         <= r_par_acc ^ w_bit_val;
            end

            if (w_cap_parity) begin
                r_perr <= w_bit_val != (r_par_acc ^ (r_parity_type == ODD));
            end

            if (w_cap_stop) begin
                r_ferr <= r_ferr | ~w_bit_val;
            end
        end
    end

    // Completion outputs: the frame error includes the stop bit being voted
    // in the completing tick, hence the live w_bit_val term.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rx_fifo_wr_data <= '0;
            o_rx_fifo_wr_en   <= 1'b0;
            o_rx_parity_err   <= 1'b0;
            o_rx_frame_err    <= 1'b0;
            o_rx_overrun_err  <= 1'b0;
        end else begin
            o_rx_fifo_wr_en  <= w_done & ~i_rx_fifo_full;
            o_rx_overrun_err <= w_done & i_rx_fifo_full;
            o_rx_parity_err  <= w_done & r_perr;
            o_rx_frame_err   <= w_done & (r_ferr | ~w_bit_val);
            if (w_done) begin
                o_rx_fifo_wr_data <= r_word;
            end
        end
    end

    assign o_rx_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pgr_uart_rx_32bit.sv
// ----------------------------------------------------------------------------
// tb_pgr_uart_rx_32bit
// Directed bench for the UART receiver. The stimulus side drives line bits
// one oversample tick at a time and queues the hand-computed completion it
// expects; a separate monitor pops that queue whenever the receiver raises
// any completion output and compares every field.
// ----------------------------------------------------------------------------
module tb_pgr_uart_rx_32bit;
    import pgr_uart_pkg::*;

    typedef struct packed {
        logic [7:0] data;
        logic       wrEn;
        logic       parityErr;
        logic       frameErr;
        logic       overrunErr;
    } expT;

    logic       clk;
    logic       rstN;
    logic       clkEn;
    logic       rxd;
    logic [1:0] wordLen;
    logic       parityEn;
    logic       parityType;
    logic       stopLen;
    logic       mode;
    logic       fifoFull;
    logic [7:0] wrData;
    logic       wrEn;
    logic       parityErr;
    logic       frameErr;
    logic       overrunErr;
    logic       busy;

    expT expQ[$];
    int  totalChecks = 0;
    int  badChecks   = 0;

    pgr_uart_rx_32bit dut (
        .clk                (clk),
        .rst_n              (rstN),
        .i_clk_en           (clkEn),
        .i_rxd              (rxd),
        .i_uart_word_len    (wordLen),
        .i_uart_parity_en   (parityEn),
        .i_uart_parity_type (parityType),
        .i_uart_stop_len    (stopLen),
        .i_uart_mode        (mode),
        .i_rx_fifo_full     (fifoFull),
        .o_rx_fifo_wr_data  (wrData),
        .o_rx_fifo_wr_en    (wrEn),
        .o_rx_parity_err    (parityErr),
        .o_rx_frame_err     (frameErr),
        .o_rx_overrun_err   (overrunErr),
        .o_rx_busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oversample tick: one clk high out of every four
    initial begin
        clkEn = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            clkEn = 1'b1;
            @(negedge clk);
            clkEn = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Returns on the negedge right after a tick has been sampled
    task automatic waitTick();
        do @(posedge clk); while (clkEn !== 1'b1);
        @(negedge clk);
    endtask

    task automatic driveSlot(input logic v, input int n);
        rxd = v;
        repeat (n) waitTick();
    endtask

    task automatic pushExp(input logic [7:0] d, input logic we, input logic pe,
                           input logic fe, input logic oe);
        expT e;
        e.data       = d;
        e.wrEn       = we;
        e.parityErr  = pe;
        e.frameErr   = fe;
        e.overrunErr = oe;
        expQ.push_back(e);
    endtask

    // Sends one frame; line bit k of the data field is lineBits[k]
    task automatic applyStimulus(input logic [1:0] wl, input logic pen,
                                 input logic ptype, input logic sl,
                                 input logic md, input logic full,
                                 input logic [7:0] lineBits, input logic parBit,
                                 input logic stop2Val, input int gapTicks);
        int nb;
        wordLen    = wl;
        parityEn   = pen;
        parityType = ptype;
        stopLen    = sl;
        mode       = md;
        fifoFull   = full;
        nb         = 5 + int'(wl);
        driveSlot(1'b0, 6);
        checkOutput("busy_in_frame", 32'(busy), 32'd1);
        for (int k = 0; k < nb; k++) begin
            driveSlot(lineBits[k], 6);
        end
        if (pen) begin
            driveSlot(parBit, 6);
        end
        driveSlot(1'b1, 6);
        if (sl) begin
            driveSlot(stop2Val, 6);
        end
        fifoFull = 1'b0;
        driveSlot(1'b1, gapTicks);
    endtask

    // Monitor: every completion is matched against the next queued entry
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (wrEn || parityErr || frameErr || overrunErr) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_out",
                                32'({wrEn, parityErr, frameErr, overrunErr}), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("wr_data",     32'(wrData),     32'(e.data));
                    checkOutput("wr_en",       32'(wrEn),       32'(e.wrEn));
                    checkOutput("parity_err",  32'(parityErr),  32'(e.parityErr));
                    checkOutput("frame_err",   32'(frameErr),   32'(e.frameErr));
                    checkOutput("overrun_err", 32'(overrunErr), 32'(e.overrunErr));
                    checkOutput("busy_at_done", 32'(busy),      32'd0);
                end
            end
        end
    end

    initial begin
        rstN       = 1'b0;
        rxd        = 1'b1;
        wordLen    = WL_8BIT;
        parityEn   = 1'b0;
        parityType = EVEN;
        stopLen    = 1'b0;
        mode       = 1'b0;
        fifoFull   = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_wr_data",     32'(wrData),     32'd0);
        checkOutput("rst_wr_en",       32'(wrEn),       32'd0);
        checkOutput("rst_parity_err",  32'(parityErr),  32'd0);
        checkOutput("rst_frame_err",   32'(frameErr),   32'd0);
        checkOutput("rst_overrun_err", 32'(overrunErr), 32'd0);
        checkOutput("rst_busy",        32'(busy),       32'd0);
        rstN = 1'b1;
        waitTick();
        driveSlot(1'b1, 6);

        $display("[TB] 8N1 LSB-first 0xA5");
        pushExp(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(WL_8BIT, 1'b0, EVEN, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 6);
        checkOutput("busy_after_a5", 32'(busy), 32'd0);

        $display("[TB] 7E1 0x55, wrong then right parity");
        pushExp(8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(WL_7BIT, 1'b1, EVEN, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b1, 6);
        pushExp(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(WL_7BIT, 1'b1, EVEN, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 6);

        $display("[TB] 6O1 0x2D, correct odd parity");
        pushExp(8'h2D, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(WL_6BIT, 1'b1, ODD, 1'b0, 1'b0, 1'b0, 8'h2D, 1'b1, 1'b1, 6);

        $display("[TB] 5N1 MSB-first, line 1,0,0,1,1");
        pushExp(8'h13, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(WL_5BIT, 1'b0, EVEN, 1'b0, 1'b1, 1'b0, 8'h19, 1'b0, 1'b1, 6);

        $display("[TB] start glitch, then 0x3C");
        wordLen = WL_8BIT;
        mode    = 1'b0;
        driveSlot(1'b0, 2);
        driveSlot(1'b1, 12);
        checkOutput("busy_after_glitch", 32'(busy), 32'd0);
        pushExp(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(WL_8BIT, 1'b0, EVEN, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 6);

        $display("[TB] 8N2 0xF0 with second stop low, then back-to-back 0x01 0x02");
        pushExp(8'hF0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(WL_8BIT, 1'b0, EVEN, 1'b1, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0, 6);
        pushExp(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(WL_8BIT, 1'b0, EVEN, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 0);
        pushExp(8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(WL_8BIT, 1'b0, EVEN, 1'b1, 1'b0, 1'b0, 8'h02, 1'b0, 1'b1, 6);

        $display("[TB] FIFO full during 0x7E");
        pushExp(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(WL_8BIT, 1'b0, EVEN, 1'b0, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b1, 6);

        $display("[TB] break: line held low for 12 bit times");
        wordLen  = WL_8BIT;
        parityEn = 1'b0;
        stopLen  = 1'b0;
        mode     = 1'b0;
        pushExp(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        driveSlot(1'b0, 72);
        checkOutput("busy_in_break", 32'(busy), 32'd0);
        driveSlot(1'b1, 12);

        $display("[TB] reset in the middle of the data field");
        driveSlot(1'b0, 6);
        driveSlot(1'b1, 6);
        driveSlot(1'b0, 3);
        checkOutput("busy_mid_data", 32'(busy), 32'd1);
        #3;
        rstN = 1'b0;
        rxd  = 1'b1;
        #1;
        checkOutput("mid_rst_wr_data",     32'(wrData),     32'd0);
        checkOutput("mid_rst_wr_en",       32'(wrEn),       32'd0);
        checkOutput("mid_rst_parity_err",  32'(parityErr),  32'd0);
        checkOutput("mid_rst_frame_err",   32'(frameErr),   32'd0);
        checkOutput("mid_rst_overrun_err", 32'(overrunErr), 32'd0);
        checkOutput("mid_rst_busy",        32'(busy),       32'd0);
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        waitTick();
        driveSlot(1'b1, 12);
        checkOutput("busy_after_rst", 32'(busy), 32'd0);

        $display("[TB] recovery frame 0x81");
        pushExp(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(WL_8BIT, 1'b0, EVEN, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 6);

        for (int i = 0; i < 200 && expQ.size() != 0; i++) begin
            @(negedge clk);
        end
        checkOutput("pending_expected", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
